alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), shift-amount width taken from b[SHAMT_W-1:0].
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 op  input  5  operation: {1'b0, legacy 4-bit ALU code} or {1'b1, RV32M funct3}.
REQ-008 a, b  input  XLEN  operands.
REQ-009 out_valid  output  1  result held valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  XLEN  operation result.
REQ-012 zero, less_than, signed_less_than  output  1 each  flags for accepted operands/result.

Function
REQ-013 Legacy codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SRL 0110, SRA 0111, SLL 1000, SLTU 1001; M codes: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
REQ-014 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of legacy op, unknown op, or M early-out case; IDLE->BUSY on accept of other M op; BUSY->DONE after final iteration; DONE->IDLE on out_ready.
REQ-015 in_ready high only in IDLE; accept = in_valid & in_ready; a, b, op registered on accept.
REQ-016 Legacy and unknown ops: out_valid rises the cycle after accept (latency 1).
REQ-017 SLT/SLTU result is zero-extended 1/0; unknown op result 0.
REQ-018 Multiply: radix-2 shift-add, one bit per cycle, XLEN iterations; out_valid rises XLEN+1 cycles after accept; MUL low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of signed*signed, signed*unsigned, unsigned*unsigned 2XLEN-bit product.
REQ-019 Divide: restoring, one quotient bit per cycle, XLEN iterations on magnitudes, sign fix-up in last cycle; latency XLEN+1.
REQ-020 Divide by zero: early out, latency 1; DIV/DIVU result all ones, REM/REMU result = a.
REQ-021 Signed overflow (a = most-negative, b = -1): early out, latency 1; DIV result = a, REM result 0.
REQ-022 zero = (result == 0) for every op; less_than = a <u b; signed_less_than = a <s b; all flags registered and valid with out_valid.
REQ-023 result and flags stable while out_valid & ~out_ready; out_valid stays high until out_ready sampled high.
REQ-024 Operand changes on a/b/op after accept have no effect on the in-flight operation.
REQ-025 out_valid & out_ready in DONE returns to IDLE; next request accepted no earlier than following cycle.

Reset
REQ-026 rst asserted: state IDLE, in_ready 1 once rst deasserts, out_valid 0, result 0, all flags 0, iteration counter 0.
REQ-027 rst mid-BUSY or mid-DONE aborts operation; no result delivered for it.

Configuration
REQ-028 Macro ALU_MD_DIV_EN defined: divider datapath and DIV/DIVU/REM/REMU compiled in per REQ-019..021.
REQ-029 ALU_MD_DIV_EN undefined: no divider logic; DIV/DIVU/REM/REMU treated as unknown ops (result 0, latency 1); multiply unaffected.

Verification
REQ-030 XLEN=32, SUB a=5 b=5 -> out_valid 1 cycle after accept, result 0, zero 1, less_than 0.
REQ-031 MULH a=0x80000000 b=0x80000000 -> out_valid 33 cycles after accept, result 0x40000000; MUL same operands -> 0.
REQ-032 With ALU_MD_DIV_EN: DIV a=-7 b=2 -> result -3; REM -> -1; DIVU a=7 b=0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000/-1 -> 0x80000000.
REQ-033 Hold out_ready 0 for 5 cycles after MULHU done -> result/flags/out_valid unchanged, in_ready 0, new in_valid ignored.
REQ-034 Assert rst at iteration 10 of DIVU -> out_valid 0, state IDLE, next ADD 3+4 returns 7 with latency 1.
REQ-035 XLEN=8, SRA a=0x80 b=0x0B (shamt 3) -> result 0xF0; SLT a=0xFF b=0x01 -> result 1, signed_less_than 1, less_than 0.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: legacy ALU plus iterative RV32M multiply/divide behind valid/ready handshakes.
// Define ALU_MD_DIV_EN to build in the restoring divider; without it the divide codes decode as unknown ops.
module alu_md #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less_than,
  output logic            signed_less_than
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0]    MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(XLEN-1);

  state_t state_q, state_d;
  logic   accept, last_iter;

  logic [SHAMT_W-1:0] shamt, cnt_q;
  logic [XLEN-1:0]    alu_res, early_res, mag_a, mag_b;
  logic               early_out, div_op, neg_d, sgn_a, sgn_b;

  logic [XLEN-1:0]    acc_q, lo_q, opnd_q, result_q;
  logic               neg_q, mul_lo_q, zero_q, lt_q, slt_q;
  logic [XLEN:0]      sum;
  logic [XLEN-1:0]    acc_n, lo_n, busy_res;
  logic [2*XLEN-1:0]  prod, prod_s;
`ifdef ALU_MD_DIV_EN
  logic               div_q, rem_sel_q;
  logic [XLEN:0]      rem_w, diff;
  logic [XLEN-1:0]    div_res;
`endif

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt_q == LAST_ITER);
  assign shamt     = b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op[3:0])
      4'b0000: alu_res = a + b;
      4'b0001: alu_res = a - b;
      4'b0010: alu_res = a & b;
      4'b0011: alu_res = a | b;
      4'b0100: alu_res = a ^ b;
      4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0110: alu_res = a >> shamt;
      4'b0111: alu_res = XLEN'($signed(a) >>> shamt);
      4'b1000: alu_res = a << shamt;
      4'b1001: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  // Decode at accept: early-out ops finish here, iterative ops load unsigned magnitudes.
  always_comb begin
    early_out = 1'b1;
    early_res = '0;
    div_op    = 1'b0;
    sgn_a     = 1'b0;
    sgn_b     = 1'b0;
    neg_d     = 1'b0;
    if (!op[4]) begin
      early_res = alu_res;
    end else if (!op[2]) begin
      early_out = 1'b0;
      sgn_a     = (op[1:0] == 2'b01 || op[1:0] == 2'b10) && a[XLEN-1];
      sgn_b     = (op[1:0] == 2'b01) && b[XLEN-1];
      neg_d     = sgn_a ^ sgn_b;
    end
`ifdef ALU_MD_DIV_EN
    else begin
      sgn_a = ~op[0] & a[XLEN-1];
      sgn_b = ~op[0] & b[XLEN-1];
      neg_d = op[1] ? sgn_a : (sgn_a ^ sgn_b);
      if (b == '0) begin
        early_res = op[1] ? a : '1;
      end else if (~op[0] && a == MIN_NEG && b == '1) begin
        early_res = op[1] ? '0 : a;
      end else begin
        early_out = 1'b0;
        div_op    = 1'b1;
      end
    end
`endif
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
  end

  // One iteration per BUSY cycle; the final cycle also applies the sign fix-up.
  always_comb begin
    sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    acc_n = sum[XLEN:1];
    lo_n  = {sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_MD_DIV_EN
    rem_w = {acc_q, lo_q[XLEN-1]};
    diff  = rem_w - {1'b0, opnd_q};
    if (div_q) begin
      acc_n = diff[XLEN] ? rem_w[XLEN-1:0] : diff[XLEN-1:0];
      lo_n  = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end
`endif
    prod     = {acc_n, lo_n};
    prod_s   = neg_q ? -prod : prod;
    busy_res = mul_lo_q ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef ALU_MD_DIV_EN
    div_res = rem_sel_q ? acc_n : lo_n;
    if (div_q) busy_res = neg_q ? -div_res : div_res;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early_out ? DONE : BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // NOTE: every state element is assigned with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      mul_lo_q  <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      slt_q     <= 1'b0;
`ifdef ALU_MD_DIV_EN
      div_q     <= 1'b0;
      rem_sel_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= div_op ? mag_a : mag_b;
      opnd_q   <= div_op ? mag_b : mag_a;
      neg_q    <= neg_d;
      mul_lo_q <= (op[1:0] == 2'b00);
      lt_q     <= (a < b);
      slt_q    <= ($signed(a) < $signed(b));
`ifdef ALU_MD_DIV_EN
      div_q     <= div_op;
      rem_sel_q <= op[1];
`endif
      if (early_out) begin
        result_q <= early_res;
        zero_q   <= (early_res == '0);
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_n;
      lo_q  <= lo_n;
      if (last_iter) begin
        result_q <= busy_res;
        zero_q   <= (busy_res == '0);
      end
    end
  end

  assign result           = result_q;
  assign zero             = zero_q;
  assign less_than        = lt_q;
  assign signed_less_than = slt_q;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed scoreboard bench for alu_md at XLEN=32 and XLEN=8.
// Divide expectations follow ALU_MD_DIV_EN, matching the RTL build.
module tb_alu_md;
  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                         OP_OR = 5'b00011, OP_XOR = 5'b00100, OP_SLT = 5'b00101,
                         OP_SRL = 5'b00110, OP_SRA = 5'b00111, OP_SLL = 5'b01000,
                         OP_SLTU = 5'b01001, OP_MUL = 5'b10000, OP_MULH = 5'b10001,
                         OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011, OP_DIV = 5'b10100,
                         OP_DIVU = 5'b10101, OP_REM = 5'b10110, OP_REMU = 5'b10111;
`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero, lt, slt;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, lt8, slt8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, result8;

  always #5 clk = ~clk;

  alu_md dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .less_than(lt), .signed_less_than(slt)
  );

  alu_md #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .zero(zero8),
    .less_than(lt8), .signed_less_than(slt8)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        slt;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model on 64-bit arithmetic; RISC-V corner cases handled explicitly.
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    logic [63:0] p;
    int sx, sy;
    sx  = x;
    sy  = y;
    lat = 1;
    r   = '0;
    p   = '0;
    if (!o[4]) begin
      case (o[3:0])
        4'd0: r = x + y;
        4'd1: r = x - y;
        4'd2: r = x & y;
        4'd3: r = x | y;
        4'd4: r = x ^ y;
        4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
        4'd6: r = x >> y[4:0];
        4'd7: r = sx >>> y[4:0];
        4'd8: r = x << y[4:0];
        4'd9: r = (x < y) ? 32'd1 : 32'd0;
        default: r = '0;
      endcase
    end else if (!o[2]) begin
      lat = 33;
      case (o[1:0])
        2'd0: p = {32'd0, x} * {32'd0, y};
        2'd1: p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        2'd2: p = $signed({{32{x[31]}}, x}) * $signed({32'd0, y});
        default: p = {32'd0, x} * {32'd0, y};
      endcase
      r = (o[1:0] == 2'd0) ? p[31:0] : p[63:32];
    end else if (DIV_EN) begin
      if (y == 32'd0) r = o[1] ? x : 32'hFFFF_FFFF;
      else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = o[1] ? 32'd0 : x;
      else begin
        lat = 33;
        case (o[1:0])
          2'd0: r = sx / sy;
          2'd1: r = x / y;
          2'd2: r = sx % sy;
          default: r = x % y;
        endcase
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] want, input bit use_want,
                     input int hold);
    exp_t        e;
    logic [31:0] r;
    int          lat, n;
    model(o, x, y, r, lat);
    if (use_want) r = want;
    e.tag = tag; e.res = r; e.z = (r == 32'd0); e.lt = (x < y);
    e.slt = ($signed(x) < $signed(y)); e.lat = lat;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    e = exp_q.pop_front();
    check({e.tag, " latency"}, 64'(n), 64'(e.lat));
    if (!out_valid) begin
      do_reset();
      return;
    end
    check({e.tag, " result"}, 64'(result), 64'(e.res));
    check({e.tag, " zero"}, 64'(zero), 64'(e.z));
    check({e.tag, " lt"}, 64'(lt), 64'(e.lt));
    check({e.tag, " slt"}, 64'(slt), 64'(e.slt));
    if (hold > 0) begin
      in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({e.tag, " hold valid/ready"}, 64'({out_valid, in_ready}), 64'd2);
        check({e.tag, " hold result"}, 64'(result), 64'(e.res));
      end
      check({e.tag, " hold flags"}, 64'({zero, lt, slt}), 64'({e.z, e.lt, e.slt}));
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({e.tag, " released"}, 64'({out_valid, in_ready}), 64'd1);
  endtask

  task automatic run8(input string tag, input logic [4:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] want, input logic want_lt,
                      input logic want_slt);
    exp_t e;
    int   n;
    e.tag = tag; e.res = {24'd0, want}; e.z = (want == 8'd0); e.lt = want_lt;
    e.slt = want_slt; e.lat = 1;
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    exp_q.push_back(e);
    #1 in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    e = exp_q.pop_front();
    check({e.tag, " latency"}, 64'(n), 64'(e.lat));
    check({e.tag, " result"}, 64'(result8), 64'(e.res[7:0]));
    check({e.tag, " flags"}, 64'({zero8, lt8, slt8}), 64'({e.z, e.lt, e.slt}));
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'({zero, lt, slt}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);

    run("add", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 0);
    run("sub_eq", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 0);
    run("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b1, 0);
    run("or", OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b1, 0);
    run("xor", OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b1, 0);
    run("slt", OP_SLT, 32'hFFFF_FFFE, 32'd3, 32'd1, 1'b1, 0);
    run("srl", OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b1, 0);
    run("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1, 0);
    run("sll", OP_SLL, 32'h0000_0003, 32'd31, 32'h8000_0000, 1'b1, 0);
    run("sltu", OP_SLTU, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b1, 0);
    run("unknown", 5'b01100, 32'd9, 32'd9, 32'd0, 1'b1, 0);
    run("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 0);
    run("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 0);
    run("mul_neg", OP_MUL, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b1, 0);
    run("mulhsu", OP_MULHSU, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    run("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0);
    run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0, 1'b1, 0);
    run("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1'b1, 0);
    run("divu_by0", OP_DIVU, 32'd7, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1'b1, 0);
    run("remu_by0", OP_REMU, 32'h1234_5678, 32'd0, DIV_EN ? 32'h1234_5678 : 32'd0, 1'b1, 0);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0, 1'b1, 0);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run("remu", OP_REMU, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, 1'b1, 0);
    run("divu_rand", OP_DIVU, $urandom, 32'd1 + 32'($urandom_range(1000)), 32'd0, 1'b0, 0);
    run("mulhu_hold", OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0FD5_BDEE, 1'b1, 5);

    // Abort a long DIVU mid-flight; no result may surface afterwards.
    in_valid = 1'b1; op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort result", 64'(result), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort no late result", 64'(out_valid), 64'd0);
    run("add_after_abort", OP_ADD, 32'd3, 32'd4, 32'd7, 1'b1, 0);

    run8("sra8", OP_SRA, 8'h80, 8'h0B, 8'hF0, 1'b0, 1'b1);
    run8("slt8", OP_SLT, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b1);
    run8("add8_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
